// File: rtl/mem_access_stage.sv
// Memory-access stage: turns MEM-stage loads/stores into a handshaked data-bus
// transaction, stalls until ack/timeout, and formats load data for writeback.
module mem_access_stage #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_mem_valid,
  input  logic             i_mem_rd,
  input  logic             i_mem_wr,
  input  logic [2:0]       i_mem_funct3,
  input  logic [WIDTH-1:0] i_mem_addr,
  input  logic [WIDTH-1:0] i_mem_wdata,
  output logic             o_bus_req,
  output logic             o_bus_we,
  output logic [WIDTH-1:0] o_bus_addr,
  output logic [3:0]       o_bus_be,
  output logic [WIDTH-1:0] o_bus_wdata,
  input  logic             i_bus_ack,
  input  logic             i_bus_err,
  input  logic [WIDTH-1:0] i_bus_rdata,
  output logic             o_mem_stall,
  output logic [WIDTH-1:0] o_mem_r_data,
  output logic             o_mem_misaligned,
  output logic             o_mem_bus_err
);
  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_BUSY  = 2'd1;
  localparam logic [1:0]  S_DONE  = 2'd2;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [15:0]      r_cnt;
  logic             r_req, r_we, r_ld, r_mis, r_berr;
  logic [WIDTH-1:0] r_addr, r_wdata, r_rdata;
  logic [3:0]       r_be;
  logic [2:0]       r_f3;
  logic [1:0]       r_off;

  logic             w_access, w_f3_ok, w_aligned, w_legal;
  logic [3:0]       w_be;
  logic [WIDTH-1:0] w_wdata, w_lane, w_ld;

  assign w_access = i_mem_valid & (i_mem_rd | i_mem_wr);

  always_comb begin
    w_f3_ok = 1'b0;
    if (i_mem_rd && i_mem_wr)
      w_f3_ok = 1'b0;
    else if (i_mem_rd)
      w_f3_ok = i_mem_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else
      w_f3_ok = i_mem_funct3 inside {3'b000, 3'b001, 3'b010};
  end

  always_comb begin
    case (i_mem_funct3[1:0])
      2'b00:   w_aligned = 1'b1;
      2'b01:   w_aligned = ~i_mem_addr[0];
      2'b10:   w_aligned = (i_mem_addr[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  assign w_legal = w_access & w_f3_ok & w_aligned;

  always_comb begin
    case (i_mem_funct3[1:0])
      2'b00:   w_be = 4'b0001 << i_mem_addr[1:0];
      2'b01:   w_be = 4'b0011 << i_mem_addr[1:0];
      default: w_be = 4'b1111;
    endcase
  end

  // Each byte lane carries the store byte that lands there: byte, half or word view of rs2.
  for (genvar k = 0; k < WIDTH / 8; k++) begin : g_lane
    assign w_wdata[8*k +: 8] =
      (i_mem_funct3[1:0] == 2'b00) ? i_mem_wdata[7:0] :
      (i_mem_funct3[1:0] == 2'b01) ? i_mem_wdata[8*(k%2) +: 8] :
                                     i_mem_wdata[8*k +: 8];
  end

  assign w_lane = i_bus_rdata >> {r_off, 3'b000};

  always_comb begin
    case (r_f3)
      3'b000:  w_ld = {{(WIDTH-8){w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_ld = {{(WIDTH-16){w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_ld = {{(WIDTH-8){1'b0}}, w_lane[7:0]};
      3'b101:  w_ld = {{(WIDTH-16){1'b0}}, w_lane[15:0]};
      default: w_ld = i_bus_rdata;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_ld    <= 1'b0;
      r_mis   <= 1'b0;
      r_berr  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_be    <= '0;
      r_f3    <= '0;
      r_off   <= '0;
    end else begin
      r_mis  <= 1'b0;
      r_berr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_legal) begin
            r_req   <= 1'b1;
            r_we    <= i_mem_wr;
            r_addr  <= {i_mem_addr[WIDTH-1:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_ld    <= i_mem_rd;
            r_f3    <= i_mem_funct3;
            r_off   <= i_mem_addr[1:0];
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end else if (w_access) begin
            r_mis <= 1'b1;
          end
        end
        S_BUSY: begin
          if (i_bus_ack) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_berr  <= i_bus_err;
            r_state <= S_DONE;
            if (r_ld) r_rdata <= w_ld;
          end else if (r_cnt == TO_LAST) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_berr  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_stall      = ((r_state == S_IDLE) & w_legal) | (r_state == S_BUSY);
  assign o_bus_req        = r_req;
  assign o_bus_we         = r_we;
  assign o_bus_addr       = r_addr;
  assign o_bus_be         = r_be;
  assign o_bus_wdata      = r_wdata;
  assign o_mem_r_data     = r_rdata;
  assign o_mem_misaligned = r_mis;
  assign o_mem_bus_err    = r_berr;

endmodule
